// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/scoreboard unit: select encoding,
// select-width helper and the per-register pending-write counter type.
package fwd_pkg;

  localparam int FWD_REGFILE    = 0;
  localparam int FWD_STAGE_BASE = 1;

  // Largest supported pending depth; pend_cnt_t is sized from it.
  localparam int PEND_MAX = 3;

  typedef logic [$clog2(PEND_MAX+1)-1:0] pend_cnt_t;

  function automatic int sel_w(input int num_fwd_stages);
    return $clog2(num_fwd_stages + 2);
  endfunction

  // Long write-back bus sits just above the last forwarding stage code.
  function automatic int fwd_long_wb(input int num_fwd_stages);
    return FWD_STAGE_BASE + num_fwd_stages;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID/EX-side bundle for the forwarding/scoreboard unit: operand indices,
// forwarding-stage state, long write-back and the select/stall results.
interface fwd_scoreboard_if #(
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_FWD_STAGES = 3
);
  localparam int SEL_W = fwd_pkg::sel_w(NUM_FWD_STAGES);

  logic [NUM_READ_PORTS*5-1:0]     id_rs;
  logic [NUM_READ_PORTS-1:0]       id_rs_used;
  logic                            id_valid;
  logic [4:0]                      id_rd;
  logic                            id_load_regfile;
  logic                            id_is_long;
  logic                            issue_advance;
  logic                            flush;
  logic [NUM_FWD_STAGES*5-1:0]     stage_rd;
  logic [NUM_FWD_STAGES-1:0]       stage_load_regfile;
  logic [NUM_FWD_STAGES-1:0]       stage_data_ready;
  logic                            long_wb_valid;
  logic [4:0]                      long_wb_rd;
  logic [NUM_READ_PORTS*SEL_W-1:0] fwd_sel;
  logic                            forward_stall;
  logic                            scoreboard_stall;
  logic [31:0]                     busy_vec;
  logic [31:0]                     stall_cycles;

  modport master (
    output id_rs, id_rs_used, id_valid, id_rd, id_load_regfile, id_is_long,
           issue_advance, flush, stage_rd, stage_load_regfile, stage_data_ready,
           long_wb_valid, long_wb_rd,
    input  fwd_sel, forward_stall, scoreboard_stall, busy_vec, stall_cycles
  );

  modport slave (
    input  id_rs, id_rs_used, id_valid, id_rd, id_load_regfile, id_is_long,
           issue_advance, flush, stage_rd, stage_load_regfile, stage_data_ready,
           long_wb_valid, long_wb_rd,
    output fwd_sel, forward_stall, scoreboard_stall, busy_vec, stall_cycles
  );
endinterface

// File: rtl/sb_counter_array.sv
// 32 saturating pending-write counters (x0 never counts) plus busy vector.
// Counts update one cycle after inc/dec; simultaneous inc and dec cancel.
module sb_counter_array
  import fwd_pkg::*;
#(
  parameter int MAX_PENDING = PEND_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_en,
  input  logic [4:0] inc_rd,
  input  logic       dec_en,
  input  logic [4:0] dec_rd,
  output pend_cnt_t  count [32],
  output logic [31:0] busy_vec
);
  localparam pend_cnt_t CNT_MAX = pend_cnt_t'(MAX_PENDING);

  logic [31:0] inc_hit;
  logic [31:0] dec_hit;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    if (inc_en && inc_rd != 5'd0) inc_hit[inc_rd] = 1'b1;
    if (dec_en && dec_rd != 5'd0) dec_hit[dec_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) count[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (inc_hit[r] && !dec_hit[r] && count[r] != CNT_MAX)
          count[r] <= count[r] + 1'b1;
        else if (dec_hit[r] && !inc_hit[r] && count[r] != '0)
          count[r] <= count[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < 32; r++) busy_vec[r] = (count[r] != '0);
  end

  // A write-back with nothing pending means the long unit and the scoreboard disagree.
  always @(posedge clk) begin
    if (rst_n && dec_hit[dec_rd] && !inc_hit[dec_rd])
      assert (count[dec_rd] != '0)
        else $error("sb_counter_array: write-back to x%0d with no pending write", dec_rd);
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Multi-stage operand forwarding plus long-latency scoreboard with RAW/WAW stalls.
// Selects and stalls are combinational; pending counts and stall counter are registered.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_FWD_STAGES = 3,
  parameter int MAX_PENDING    = PEND_MAX
) (
  input  logic clk,
  input  logic rst_n,
  fwd_scoreboard_if.slave bus
);
  localparam int SEL_W = sel_w(NUM_FWD_STAGES);
  localparam int FWD_LONG_WB = fwd_long_wb(NUM_FWD_STAGES);
  localparam pend_cnt_t CNT_MAX = pend_cnt_t'(MAX_PENDING);

  pend_cnt_t   count [32];
  logic [31:0] wb_vec;
  logic [31:0] pend_block;
  logic [NUM_READ_PORTS*SEL_W-1:0] sel_flat;
  logic [4:0]       rs;
  logic             hit;
  logic             rdy;
  logic [SEL_W-1:0] sel;
  logic fwd_stall;
  logic raw_stall;
  logic waw_stall;
  logic sat_stall;
  logic sb_stall;
  logic issue;

  // A register blocks unless its only pending write is landing this cycle.
  always_comb begin
    wb_vec     = '0;
    pend_block = '0;
    if (bus.long_wb_valid) wb_vec[bus.long_wb_rd] = 1'b1;
    for (int r = 0; r < 32; r++)
      pend_block[r] = (count[r] != '0) && !((count[r] == pend_cnt_t'(1)) && wb_vec[r]);
  end

  always_comb begin
    sel_flat  = '0;
    fwd_stall = 1'b0;
    raw_stall = 1'b0;
    rs        = '0;
    hit       = 1'b0;
    rdy       = 1'b1;
    sel       = SEL_W'(FWD_REGFILE);
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rs  = bus.id_rs[p*5 +: 5];
      hit = 1'b0;
      rdy = 1'b1;
      sel = SEL_W'(FWD_REGFILE);
      // Walk oldest to youngest so the youngest matching stage wins.
      for (int k = NUM_FWD_STAGES-1; k >= 0; k--) begin
        if (bus.stage_load_regfile[k] && bus.stage_rd[k*5 +: 5] == rs) begin
          hit = 1'b1;
          rdy = bus.stage_data_ready[k];
          sel = SEL_W'(FWD_STAGE_BASE + k);
        end
      end
      if (!hit && wb_vec[rs]) sel = SEL_W'(FWD_LONG_WB);
      if (bus.id_valid && bus.id_rs_used[p] && rs != 5'd0) begin
        sel_flat[p*SEL_W +: SEL_W] = sel;
        if (hit && !rdy) fwd_stall = 1'b1;
        if (pend_block[rs]) raw_stall = 1'b1;
      end
    end
  end

  // Long ops may stack on one rd (they retire in order); only short writers see WAW.
  assign waw_stall = bus.id_valid && bus.id_load_regfile && !bus.id_is_long &&
                     bus.id_rd != 5'd0 && pend_block[bus.id_rd];
  assign sat_stall = bus.id_valid && bus.id_is_long && count[bus.id_rd] == CNT_MAX;
  assign sb_stall  = raw_stall || waw_stall || sat_stall;
  assign issue     = bus.id_valid && bus.issue_advance && !bus.flush && !fwd_stall && !sb_stall;

  sb_counter_array #(.MAX_PENDING(MAX_PENDING)) u_counters (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_en   (issue && bus.id_is_long && bus.id_load_regfile),
    .inc_rd   (bus.id_rd),
    .dec_en   (bus.long_wb_valid),
    .dec_rd   (bus.long_wb_rd),
    .count    (count),
    .busy_vec (bus.busy_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.stall_cycles <= '0;
    else if (bus.id_valid && (fwd_stall || sb_stall))
      bus.stall_cycles <= bus.stall_cycles + 32'd1;
  end

  assign bus.fwd_sel          = sel_flat;
  assign bus.forward_stall    = fwd_stall;
  assign bus.scoreboard_stall = sb_stall;

endmodule
